// File: rtl/inst_pcm_serializer.sv
// ---------------------------------------------------------------------------
// inst_pcm_serializer
//
// Purpose:
//   Serializes one accepted instruct word into a framed NRZ bit stream for the
//   PCM modulator. A frame is the sync word, then the payload (MSB first from
//   bit DATA_W-1), then an optional CRC-16. Each bit is held for a
//   configurable number of clk_sys cycles. A one-cycle strobe marks the first
//   cycle of every new bit.
//
// Optional feature:
//   PCM_CRC16_EN   when defined, appends CRC-16/CCITT-FALSE (poly 0x1021,
//                  init 0xFFFF, no reflection, no final xor) over the payload
//                  bits, sent MSB first at the same baud.
//
// Parameters:
//   U_DLY    register assignment delay of the legacy behavioural model; kept
//            for instantiation compatibility, no delay is modelled here
//   DATA_W   instruct word width (at most 1023, the bit index is 10 bits)
//
// Ports:
//   clk_sys              in   system clock
//   rst_n                in   asynchronous active-low reset
//   cfg_pcm_bitlen       in   payload bits per frame, 0 ignores the frame,
//                             values above DATA_W clamp to DATA_W
//   cfg_pcm_baud_div     in   clk_sys cycles per bit, 0 or 1 act as 2
//   cfg_pcm_sync         in   sync word, right-aligned
//   cfg_pcm_sync_len     in   sync bits sent, values above 32 clamp to 32
//   cfg_pcm_idle_lvl     in   line level while idle
//   pcm_inst_data        in   instruct word
//   pcm_inst_data_valid  in   one-cycle strobe, accepted only while idle
//   pcm_bit_out          out  serial NRZ bit
//   pcm_bit_en           out  pulse on the first cycle of each new bit
//   pcm_busy             out  high from frame start through the done cycle
//   pcm_tx_done          out  pulse in the single cycle after the last bit
//   debug_pcm_overflow   out  pulse one cycle after a strobe arrives while busy
// ---------------------------------------------------------------------------
module inst_pcm_serializer #(
   parameter int U_DLY  = 1,
   parameter int DATA_W = 512
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic [15:0]       cfg_pcm_bitlen,
   input  logic [15:0]       cfg_pcm_baud_div,
   input  logic [31:0]       cfg_pcm_sync,
   input  logic [5:0]        cfg_pcm_sync_len,
   input  logic              cfg_pcm_idle_lvl,
   input  logic [DATA_W-1:0] pcm_inst_data,
   input  logic              pcm_inst_data_valid,
   output logic              pcm_bit_out,
   output logic              pcm_bit_en,
   output logic              pcm_busy,
   output logic              pcm_tx_done,
   output logic              debug_pcm_overflow
);

   // No assignment delay is applied in this model; the parameter is only
   // referenced so that existing instantiations keep elaborating.
   if (U_DLY < 0) begin : gLegacyDly
   end

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
`ifdef PCM_CRC16_EN
      CRC,
`endif
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       baud_q, baud_d;
   logic [9:0]        bitIdx_q, bitIdx_d;
   logic [31:0]       syncSh_q, syncSh_d;
   logic [DATA_W-1:0] dataSh_q, dataSh_d;
   logic [9:0]        bitLen_q, bitLen_d;
   logic [5:0]        syncLen_q, syncLen_d;
   logic [15:0]       div_q, div_d;
   logic              idleLvl_q, idleLvl_d;
   logic              bitOut_q, bitOut_d;
   logic              bitEn_q, bitEn_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
`ifdef PCM_CRC16_EN
   logic [15:0]       crc_q, crc_d;
`endif

   logic [9:0]        bitLenClamp;
   logic [5:0]        syncLenClamp;
   logic [15:0]       divClamp;
   logic [31:0]       syncAligned;
   logic [9:0]        curLen;
   logic              load;
   state_t            loadSt;

`ifdef PCM_CRC16_EN
   // One bit-serial step of CRC-16/CCITT-FALSE.
   function automatic logic [15:0] crcStep(input logic [15:0] crcIn, input logic bitIn);
      logic fb;
      fb = crcIn[15] ^ bitIn;
      crcStep = {crcIn[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction
`endif

   // Clamp the live configuration to legal ranges. The sync word is shifted
   // so its first transmitted bit lands in bit 31, which lets the SYNC state
   // simply shift left.
   assign bitLenClamp  = (cfg_pcm_bitlen > 16'(DATA_W)) ? 10'(DATA_W) : cfg_pcm_bitlen[9:0];
   assign syncLenClamp = (cfg_pcm_sync_len > 6'd32) ? 6'd32 : cfg_pcm_sync_len;
   assign divClamp     = (cfg_pcm_baud_div < 16'd2) ? 16'd2 : cfg_pcm_baud_div;
   assign syncAligned  = cfg_pcm_sync << (6'd32 - syncLenClamp);

   // Number of bits the current field sends, from the latched frame copy.
   always_comb begin
      curLen = 10'd1;
      case (state_q)
         SYNC:    curLen = {4'd0, syncLen_q};
         DATA:    curLen = bitLen_q;
`ifdef PCM_CRC16_EN
         CRC:     curLen = 10'd16;
`endif
         default: curLen = 10'd1;
      endcase
   end

   // Frame sequencing. The baud counter counts cycles within the current bit;
   // on the last cycle of a bit the next bit (or the done cycle) is loaded
   // into the output register, so bits are always held exactly div cycles.
   // Acceptance loads the first bit directly so it appears on the very next
   // cycle together with the bit strobe.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bitIdx_d  = bitIdx_q;
      syncSh_d  = syncSh_q;
      dataSh_d  = dataSh_q;
      bitLen_d  = bitLen_q;
      syncLen_d = syncLen_q;
      div_d     = div_q;
      idleLvl_d = idleLvl_q;
      bitOut_d  = bitOut_q;
      bitEn_d   = 1'b0;
`ifdef PCM_CRC16_EN
      crc_d     = crc_q;
`endif
      load      = 1'b0;
      loadSt    = IDLE;
      ovf_d     = pcm_inst_data_valid && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            bitOut_d = cfg_pcm_idle_lvl;
            if (pcm_inst_data_valid && (bitLenClamp != 10'd0)) begin
               bitLen_d  = bitLenClamp;
               syncLen_d = syncLenClamp;
               div_d     = divClamp;
               idleLvl_d = cfg_pcm_idle_lvl;
               baud_d    = '0;
               bitIdx_d  = '0;
               bitEn_d   = 1'b1;
`ifdef PCM_CRC16_EN
               crc_d     = 16'hFFFF;
`endif
               if (syncLenClamp != 6'd0) begin
                  state_d  = SYNC;
                  bitOut_d = syncAligned[31];
                  syncSh_d = syncAligned << 1;
                  dataSh_d = pcm_inst_data;
               end else begin
                  state_d  = DATA;
                  bitOut_d = pcm_inst_data[DATA_W-1];
                  syncSh_d = '0;
                  dataSh_d = pcm_inst_data << 1;
`ifdef PCM_CRC16_EN
                  crc_d    = crcStep(16'hFFFF, pcm_inst_data[DATA_W-1]);
`endif
               end
            end
         end

         DONE: begin
            state_d  = IDLE;
            bitOut_d = cfg_pcm_idle_lvl;
         end

         default: begin
            if (baud_q == div_q - 16'd1) begin
               baud_d = '0;
               load   = 1'b1;
               if (bitIdx_q == curLen - 10'd1) begin
                  bitIdx_d = '0;
                  case (state_q)
                     SYNC:    loadSt = DATA;
`ifdef PCM_CRC16_EN
                     DATA:    loadSt = CRC;
`else
                     DATA:    loadSt = DONE;
`endif
                     default: loadSt = DONE;
                  endcase
               end else begin
                  bitIdx_d = bitIdx_q + 10'd1;
                  loadSt   = state_q;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
      endcase

      // Present the next bit of whichever field is active from here on. The
      // CRC absorbs each payload bit as it goes out, so it is final by the
      // time the CRC field starts.
      if (load) begin
         state_d = loadSt;
         case (loadSt)
            SYNC: begin
               bitEn_d  = 1'b1;
               bitOut_d = syncSh_q[31];
               syncSh_d = syncSh_q << 1;
            end
            DATA: begin
               bitEn_d  = 1'b1;
               bitOut_d = dataSh_q[DATA_W-1];
               dataSh_d = dataSh_q << 1;
`ifdef PCM_CRC16_EN
               crc_d    = crcStep(crc_q, dataSh_q[DATA_W-1]);
`endif
            end
`ifdef PCM_CRC16_EN
            CRC: begin
               bitEn_d  = 1'b1;
               bitOut_d = crc_q[15];
               crc_d    = {crc_q[14:0], 1'b0};
            end
`endif
            default: begin
               bitOut_d = idleLvl_q;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and output registers. Reset aborts any frame immediately and
   // produces no done pulse.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bitIdx_q  <= '0;
         syncSh_q  <= '0;
         dataSh_q  <= '0;
         bitLen_q  <= '0;
         syncLen_q <= '0;
         div_q     <= '0;
         idleLvl_q <= 1'b0;
         bitOut_q  <= 1'b0;
         bitEn_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
`ifdef PCM_CRC16_EN
         crc_q     <= 16'hFFFF;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bitIdx_q  <= bitIdx_d;
         syncSh_q  <= syncSh_d;
         dataSh_q  <= dataSh_d;
         bitLen_q  <= bitLen_d;
         syncLen_q <= syncLen_d;
         div_q     <= div_d;
         idleLvl_q <= idleLvl_d;
         bitOut_q  <= bitOut_d;
         bitEn_q   <= bitEn_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
`ifdef PCM_CRC16_EN
         crc_q     <= crc_d;
`endif
      end
   end

   assign pcm_bit_out        = bitOut_q;
   assign pcm_bit_en         = bitEn_q;
   assign pcm_busy           = busy_q;
   assign pcm_tx_done        = done_q;
   assign debug_pcm_overflow = ovf_q;

endmodule

// File: tb/tb_inst_pcm_serializer.sv
// ---------------------------------------------------------------------------
// tb_inst_pcm_serializer
//
// Purpose:
//   Self-checking bench for inst_pcm_serializer. Expected bits are pushed to a
//   queue when a frame is driven and popped as the serializer strobes each
//   bit out. Frame timing, busy length, overflow and reset behaviour are
//   checked at directed points. Define PCM_CRC16_EN to exercise the CRC field.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_pcm_serializer;

   localparam int DATA_W = 512;
`ifdef PCM_CRC16_EN
   localparam int CrcBits = 16;
`else
   localparam int CrcBits = 0;
`endif

   logic              clk_sys = 1'b0;
   logic              rst_n;
   logic [15:0]       cfg_pcm_bitlen;
   logic [15:0]       cfg_pcm_baud_div;
   logic [31:0]       cfg_pcm_sync;
   logic [5:0]        cfg_pcm_sync_len;
   logic              cfg_pcm_idle_lvl;
   logic [DATA_W-1:0] pcm_inst_data;
   logic              pcm_inst_data_valid;
   logic              pcm_bit_out;
   logic              pcm_bit_en;
   logic              pcm_busy;
   logic              pcm_tx_done;
   logic              debug_pcm_overflow;

   inst_pcm_serializer #(.U_DLY(1), .DATA_W(DATA_W)) dut (
      .clk_sys             (clk_sys),
      .rst_n               (rst_n),
      .cfg_pcm_bitlen      (cfg_pcm_bitlen),
      .cfg_pcm_baud_div    (cfg_pcm_baud_div),
      .cfg_pcm_sync        (cfg_pcm_sync),
      .cfg_pcm_sync_len    (cfg_pcm_sync_len),
      .cfg_pcm_idle_lvl    (cfg_pcm_idle_lvl),
      .pcm_inst_data       (pcm_inst_data),
      .pcm_inst_data_valid (pcm_inst_data_valid),
      .pcm_bit_out         (pcm_bit_out),
      .pcm_bit_en          (pcm_bit_en),
      .pcm_busy            (pcm_busy),
      .pcm_tx_done         (pcm_tx_done),
      .debug_pcm_overflow  (debug_pcm_overflow)
   );

   always #5 clk_sys = ~clk_sys;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   tStart = 0;
   int   busyCnt = 0;
   int   doneCnt = 0;
   int   ovfCnt  = 0;
   int   frameEn = 0;
   int   lastEnCyc = 0;
   int   expGap = 2;
   logic expQ[$];

   // Cycle counter; a strobe driven while cyc == T is sampled on the edge
   // that moves cyc to T+1.
   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Bit monitor: every strobed bit is popped from the scoreboard and its
   // spacing from the previous strobe of the same frame is checked.
   always @(negedge clk_sys) begin
      logic e;
      if (rst_n) begin
         if (pcm_busy) busyCnt++;
         if (pcm_tx_done) doneCnt++;
         if (debug_pcm_overflow) ovfCnt++;
         if (pcm_bit_en) begin
            if (frameEn > 0) checkOutput("bit_gap", cyc - lastEnCyc, expGap);
            frameEn++;
            lastEnCyc = cyc;
            checkOutput("bit_expected", (expQ.size() != 0), 1'b1);
            if (expQ.size() != 0) begin
               e = expQ.pop_front();
               checkOutput("bit_value", pcm_bit_out, e);
            end
         end
      end
   end

   // Reference frame: sync bits, payload bits, then the CRC when enabled.
   task automatic pushFrame(input logic [DATA_W-1:0] d, input int bl, input logic [31:0] s, input int sl);
      logic b;
`ifdef PCM_CRC16_EN
      logic [15:0] c;
      c = 16'hFFFF;
`endif
      for (int i = sl - 1; i >= 0; i--) expQ.push_back(s[i]);
      for (int i = 0; i < bl; i++) begin
         b = d[DATA_W-1-i];
         expQ.push_back(b);
`ifdef PCM_CRC16_EN
         if (c[15] ^ b) c = (c << 1) ^ 16'h1021;
         else           c = c << 1;
`endif
      end
`ifdef PCM_CRC16_EN
      for (int i = 15; i >= 0; i--) expQ.push_back(c[i]);
`endif
   endtask

   // Drive one strobe on the next cycle; returns one cycle later with the
   // strobe removed.
   task automatic applyStimulus(input logic [DATA_W-1:0] d, input int bl, input int dv, input logic [31:0] s, input int sl, input logic idle, input bit accept);
      int blC;
      int slC;
      @(posedge clk_sys);
      #1;
      cfg_pcm_bitlen      = 16'(bl);
      cfg_pcm_baud_div    = 16'(dv);
      cfg_pcm_sync        = s;
      cfg_pcm_sync_len    = 6'(sl);
      cfg_pcm_idle_lvl    = idle;
      pcm_inst_data       = d;
      pcm_inst_data_valid = 1'b1;
      tStart  = cyc;
      busyCnt = 0;
      if (accept) begin
         blC = (bl > DATA_W) ? DATA_W : bl;
         slC = (sl > 32) ? 32 : sl;
         frameEn = 0;
         expGap  = (dv < 2) ? 2 : dv;
         pushFrame(d, blC, s, slC);
      end
      @(posedge clk_sys);
      #1;
      pcm_inst_data_valid = 1'b0;
   endtask

   // Wait for the done pulse, then check latency, busy length, bit count
   // and line level; returns during the done cycle.
   task automatic waitDone(input int budget, input int expLat, input int expBits, input logic expIdle, input string tag);
      bit seen;
      seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk_sys);
         if (pcm_tx_done) seen = 1;
      end
      checkOutput({tag, "_done_seen"}, seen, 1'b1);
      if (seen) begin
         #1;
         checkOutput({tag, "_done_latency"}, cyc - tStart, expLat);
         checkOutput({tag, "_busy_cycles"}, busyCnt, expLat);
         checkOutput({tag, "_busy_in_done"}, pcm_busy, 1'b1);
         checkOutput({tag, "_line_in_done"}, pcm_bit_out, expIdle);
         checkOutput({tag, "_bit_count"}, frameEn, expBits);
         checkOutput({tag, "_queue_drained"}, expQ.size(), 0);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_bit_out"}, pcm_bit_out, 1'b0);
      checkOutput({tag, "_bit_en"}, pcm_bit_en, 1'b0);
      checkOutput({tag, "_busy"}, pcm_busy, 1'b0);
      checkOutput({tag, "_done"}, pcm_tx_done, 1'b0);
      checkOutput({tag, "_overflow"}, debug_pcm_overflow, 1'b0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [DATA_W-1:0] dA5;
      logic [DATA_W-1:0] dOne;
      logic [DATA_W-1:0] dAlt;
      logic [DATA_W-1:0] dRnd;
      int ovf0;
      int done0;

      dA5  = '0; dA5[DATA_W-1 -: 8] = 8'hA5;
      dOne = '0; dOne[DATA_W-1] = 1'b1;
      dAlt = '1;
      dRnd = '0;
      for (int i = 0; i < DATA_W / 32; i++) dRnd[i*32 +: 32] = $urandom;

      rst_n               = 1'b0;
      cfg_pcm_bitlen      = '0;
      cfg_pcm_baud_div    = '0;
      cfg_pcm_sync        = '0;
      cfg_pcm_sync_len    = '0;
      cfg_pcm_idle_lvl    = 1'b1;
      pcm_inst_data       = '0;
      pcm_inst_data_valid = 1'b0;

      $display("[TB] reset values");
      repeat (2) @(negedge clk_sys);
      checkResetOutputs("reset");

      @(posedge clk_sys);
      #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      checkOutput("idle_level_high", pcm_bit_out, 1'b1);
      cfg_pcm_idle_lvl = 1'b0;
      repeat (2) @(negedge clk_sys);
      checkOutput("idle_level_low", pcm_bit_out, 1'b0);

      $display("[TB] sync EB90 plus A5, div 4");
      applyStimulus(dA5, 8, 4, 32'h0000EB90, 16, 1'b0, 1'b1);
      @(negedge clk_sys);
      checkOutput("t1_first_strobe", pcm_bit_en, 1'b1);
      checkOutput("t1_first_bit", pcm_bit_out, 1'b1);
      checkOutput("t1_busy_start", pcm_busy, 1'b1);
      waitDone(300, (24 + CrcBits) * 4 + 1, 24 + CrcBits, 1'b0, "t1");

      $display("[TB] overflow during a frame");
      ovf0 = ovfCnt;
      applyStimulus(dA5, 8, 4, 32'h0000EB90, 16, 1'b0, 1'b1);
      repeat (9) @(posedge clk_sys);
      #1;
      cfg_pcm_baud_div    = 16'd2;
      cfg_pcm_sync_len    = 6'd8;
      cfg_pcm_idle_lvl    = 1'b1;
      pcm_inst_data       = dAlt;
      pcm_inst_data_valid = 1'b1;
      @(posedge clk_sys);
      #1;
      pcm_inst_data_valid = 1'b0;
      @(negedge clk_sys);
      checkOutput("t3_overflow_cycle", cyc - tStart, 11);
      checkOutput("t3_overflow_pulse", debug_pcm_overflow, 1'b1);
      @(negedge clk_sys);
      checkOutput("t3_overflow_single", debug_pcm_overflow, 1'b0);
      waitDone(300, (24 + CrcBits) * 4 + 1, 24 + CrcBits, 1'b0, "t3");
      checkOutput("t3_overflow_count", ovfCnt - ovf0, 1);

      $display("[TB] single bit, div 0");
      applyStimulus(dOne, 1, 0, 32'h0, 0, 1'b0, 1'b1);
      waitDone(100, (1 + CrcBits) * 2 + 1, 1 + CrcBits, 1'b0, "t2");
      @(negedge clk_sys);
      checkOutput("t2_idle_after", pcm_bit_out, 1'b0);
      checkOutput("t2_busy_after", pcm_busy, 1'b0);

      $display("[TB] zero bitlen ignored");
      ovf0  = ovfCnt;
      done0 = doneCnt;
      applyStimulus(dA5, 0, 4, 32'h0000EB90, 16, 1'b0, 1'b0);
      repeat (10) @(negedge clk_sys);
      #1;
      checkOutput("t4_zero_busy", busyCnt, 0);
      checkOutput("t4_zero_done", doneCnt - done0, 0);
      checkOutput("t4_zero_overflow", ovfCnt - ovf0, 0);

      $display("[TB] bitlen clamp then back-to-back frame");
      applyStimulus(dRnd, 600, 2, 32'h0, 0, 1'b0, 1'b1);
      waitDone(2000, (DATA_W + CrcBits) * 2 + 1, DATA_W + CrcBits, 1'b0, "t4_clamp");
      ovf0 = ovfCnt;
      applyStimulus(~dRnd, 3, 3, 32'hDEADBEEF, 40, 1'b1, 1'b1);
      waitDone(300, (35 + CrcBits) * 3 + 1, 35 + CrcBits, 1'b1, "t4_b2b");
      checkOutput("t4_b2b_no_overflow", ovfCnt - ovf0, 0);

      $display("[TB] reset in mid frame");
      applyStimulus(dA5, 8, 4, 32'h0000EB90, 16, 1'b0, 1'b1);
      for (int i = 0; i < 100 && frameEn < 5; i++) @(negedge clk_sys);
      checkOutput("t5_reached_bit5", (frameEn >= 5), 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkResetOutputs("t5_async");
      expQ.delete();
      done0 = doneCnt;
      repeat (4) @(negedge clk_sys);
      checkResetOutputs("t5_held");
      @(posedge clk_sys);
      #1;
      rst_n = 1'b1;
      checkOutput("t5_no_done", doneCnt - done0, 0);
      applyStimulus(dOne, 1, 0, 32'h0, 0, 1'b0, 1'b1);
      waitDone(100, (1 + CrcBits) * 2 + 1, 1 + CrcBits, 1'b0, "t5_restart");

`ifdef PCM_CRC16_EN
      $display("[TB] CRC over 123456789");
      dRnd = '0;
      dRnd[DATA_W-1 -: 72] = 72'h313233343536373839;
      applyStimulus(dRnd, 72, 2, 32'h0, 0, 1'b0, 1'b1);
      waitDone(400, 88 * 2 + 1, 88, 1'b0, "t6_crc");
`endif

      repeat (2) @(negedge clk_sys);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
